// File: rtl/sd_loader_pkg.sv
// Shared types, ASCII command codes and the hex digit decoder for the
// UART hex sample loader.
package sd_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_UL = 8'h4C;
  localparam logic [7:0] ASCII_LL = 8'h6C;
  localparam logic [7:0] ASCII_UX = 8'h58;
  localparam logic [7:0] ASCII_LX = 8'h78;

  // Returns {is_hex, nibble}; nibble is zero for non-hex characters.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
    logic [7:0] d;
    logic [4:0] r;
    d = 8'h00;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      d = c - 8'h30;
      r = {1'b1, d[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      d = c - 8'h37;
      r = {1'b1, d[3:0]};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      d = c - 8'h57;
      r = {1'b1, d[3:0]};
    end else begin
      r = 5'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_line_parser.sv
// Assembles one ASCII-hex line into a right-aligned sample and reports
// the outcome as registered one-cycle pulses when the LF arrives.
module hex_line_parser
  import sd_loader_pkg::*;
#(
  parameter int SAMPLE_BITLEN = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     byte_valid,
  input  logic [7:0]               rx_byte,
  output logic                     line_done,
  output logic                     line_ok,
  output logic                     line_err,
  output logic [SAMPLE_BITLEN-1:0] line_value
);

  localparam int MAX_DIGITS = SAMPLE_BITLEN / 4;
  localparam int CW         = $clog2(MAX_DIGITS + 1);

  logic [SAMPLE_BITLEN-1:0] acc_r, acc_s;
  logic [CW-1:0]            cnt_r, cnt_s;
  logic                     err_r, err_s;
  logic                     done_r, done_s;
  logic                     ok_r, ok_s;
  logic                     lerr_r, lerr_s;
  logic [SAMPLE_BITLEN-1:0] value_r, value_s;
  logic [4:0]               nib_s;

  // Next-state of accumulator, digit count, error flag and line result.
  always_comb begin
    nib_s   = hex_to_nibble(rx_byte);
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    done_s  = 1'b0;
    ok_s    = 1'b0;
    lerr_s  = 1'b0;
    value_s = value_r;
    if (clear) begin
      acc_s = '0;
      cnt_s = '0;
      err_s = 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == ASCII_LF) begin
        done_s  = 1'b1;
        ok_s    = ~err_r & (cnt_r != '0);
        lerr_s  = err_r;
        value_s = acc_r;
        acc_s   = '0;
        cnt_s   = '0;
        err_s   = 1'b0;
      end else if (rx_byte == ASCII_CR) begin
        acc_s = acc_r;
      end else if (nib_s[4]) begin
        // Once flagged, the line is dead until LF; a digit past the limit kills it.
        if (err_r) begin
          acc_s = acc_r;
        end else if (cnt_r == CW'(MAX_DIGITS)) begin
          err_s = 1'b1;
        end else begin
          acc_s = {acc_r[SAMPLE_BITLEN-5:0], nib_s[3:0]};
          cnt_s = cnt_r + CW'(1);
        end
      end else begin
        err_s = 1'b1;
      end
    end else begin
      acc_s = acc_r;
    end
  end

  // Parser state and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r   <= '0;
      cnt_r   <= '0;
      err_r   <= 1'b0;
      done_r  <= 1'b0;
      ok_r    <= 1'b0;
      lerr_r  <= 1'b0;
      value_r <= '0;
    end else begin
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      done_r  <= done_s;
      ok_r    <= ok_s;
      lerr_r  <= lerr_s;
      value_r <= value_s;
    end
  end

  assign line_done  = done_r;
  assign line_ok    = ok_r;
  assign line_err   = lerr_r;
  assign line_value = value_r;

endmodule

// File: rtl/uart_hex_sample_loader.sv
// UART hex sample loader: fills a sample buffer from hex lines, then replays it
// to a DAC on request. Define UART_HEX_SAMPLE_LOADER_ECHO_EN to echo received bytes.
module uart_hex_sample_loader
  import sd_loader_pkg::*;
#(
  parameter int NUM_SAMPLES   = 1024,
  parameter int SAMPLE_BITLEN = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rvalid,
  output logic                           rready,
  input  logic [7:0]                     rdata,
  input  logic                           dac_req,
  output logic [SAMPLE_BITLEN-1:0]       sample_out,
  output logic                           sample_valid,
  output logic [1:0]                     state_out,
  output logic [$clog2(NUM_SAMPLES):0]   load_count,
  output logic [7:0]                     err_count
`ifdef UART_HEX_SAMPLE_LOADER_ECHO_EN
  ,
  output logic                           tvalid,
  input  logic                           tready,
  output logic [7:0]                     tdata
`endif
);

  localparam int AW = $clog2(NUM_SAMPLES);
  localparam int LW = AW + 1;

  state_t                   state_r, state_s;
  logic                     enter_load_s;
  logic                     consume_s, is_l_s, is_x_s;
  logic                     rready_r, rready_s;
  logic [LW-1:0]            load_count_r;
  logic [7:0]               err_count_r;
  logic [AW-1:0]            rd_idx_r;
  logic [SAMPLE_BITLEN-1:0] sample_out_r;
  logic                     sample_valid_r;
  logic [SAMPLE_BITLEN-1:0] mem_r [NUM_SAMPLES];
  logic                     line_done_s, line_ok_s, line_err_s;
  logic [SAMPLE_BITLEN-1:0] line_value_s;

  assign consume_s = rvalid & rready_r;
  assign is_l_s    = (rdata == ASCII_UL) | (rdata == ASCII_LL);
  assign is_x_s    = (rdata == ASCII_UX) | (rdata == ASCII_LX);

  hex_line_parser #(
    .SAMPLE_BITLEN (SAMPLE_BITLEN)
  ) u_parser (
    .clk        (clk),
    .rst        (rst),
    .clear      (enter_load_s),
    .byte_valid (consume_s & (state_r == ST_LOAD)),
    .rx_byte    (rdata),
    .line_done  (line_done_s),
    .line_ok    (line_ok_s),
    .line_err   (line_err_s),
    .line_value (line_value_s)
  );

`ifdef UART_HEX_SAMPLE_LOADER_ECHO_EN
  logic       tvalid_r, tvalid_s;
  logic [7:0] tdata_r;

  // Echo slot fills on every consumed byte; rready stays low while it is occupied.
  always_comb begin
    tvalid_s = consume_s | (tvalid_r & ~tready);
    rready_s = rvalid & ~consume_s & ~tvalid_s;
  end

  // Echo holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_r <= 1'b0;
      tdata_r  <= 8'h00;
    end else begin
      tvalid_r <= tvalid_s;
      if (consume_s) begin
        tdata_r <= rdata;
      end
    end
  end

  assign tvalid = tvalid_r;
  assign tdata  = tdata_r;
`else
  // Without echo, accept at most one byte every other cycle.
  always_comb begin
    rready_s = rvalid & ~consume_s;
  end
`endif

  // Mode FSM next-state; a command byte and dac_req in one cycle both take effect.
  always_comb begin
    state_s      = state_r;
    enter_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (consume_s && is_l_s) begin
          state_s      = ST_LOAD;
          enter_load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (line_ok_s && (load_count_r == LW'(NUM_SAMPLES - 1))) begin
          state_s = ST_PLAY;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_PLAY: begin
        if (consume_s && is_x_s) begin
          state_s = ST_IDLE;
        end else if (consume_s && is_l_s) begin
          state_s      = ST_LOAD;
          enter_load_s = 1'b1;
        end else begin
          state_s = ST_PLAY;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, handshake and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      rready_r     <= 1'b0;
      load_count_r <= '0;
      err_count_r  <= 8'h00;
      rd_idx_r     <= '0;
    end else begin
      state_r  <= state_s;
      rready_r <= rready_s;
      if (enter_load_s) begin
        load_count_r <= '0;
      end else if (state_r == ST_LOAD && line_ok_s) begin
        load_count_r <= load_count_r + LW'(1);
      end
      if (state_r == ST_LOAD && line_err_s && err_count_r != 8'hFF) begin
        err_count_r <= err_count_r + 8'h01;
      end
      if (state_r == ST_LOAD && state_s == ST_PLAY) begin
        rd_idx_r <= '0;
      end else if (state_r == ST_PLAY && dac_req) begin
        rd_idx_r <= rd_idx_r + AW'(1);
      end
    end
  end

  // Sample buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (state_r == ST_LOAD && line_ok_s) begin
      mem_r[load_count_r[AW-1:0]] <= line_value_s;
    end
  end

  // Playback read port with one-cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_out_r   <= '0;
      sample_valid_r <= 1'b0;
    end else if (state_r == ST_PLAY && dac_req) begin
      sample_out_r   <= mem_r[rd_idx_r];
      sample_valid_r <= 1'b1;
    end else begin
      sample_valid_r <= 1'b0;
    end
  end

  assign rready       = rready_r;
  assign sample_out   = sample_out_r;
  assign sample_valid = sample_valid_r;
  assign state_out    = state_r;
  assign load_count   = load_count_r;
  assign err_count    = err_count_r;

endmodule

// File: tb/tb_uart_hex_sample_loader.sv
// Scoreboard bench for uart_hex_sample_loader: loads via UART bytes, replays,
// and checks command, error and reset behaviour.
module tb_uart_hex_sample_loader;

  localparam int NS = 1024;
  localparam int SB = 24;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          rvalid;
  logic          rready;
  logic [7:0]    rdata;
  logic          dac_req;
  logic [SB-1:0] sample_out;
  logic          sample_valid;
  logic [1:0]    state_out;
  logic [LW-1:0] load_count;
  logic [7:0]    err_count;
  logic          tvalid;
  logic          tready;
  logic [7:0]    tdata;

  int checks = 0;
  int errors = 0;

  logic [SB-1:0] model [NS];
  int            rd_model;
  logic [SB-1:0] exp_q [$];
  logic [SB-1:0] mon_exp;
  logic [SB-1:0] last_out;
  bit            exp_play = 1'b0;
  bit            mon_en = 1'b0;
  logic          tb_req_d = 1'b0;
  logic          rst_d = 1'b0;

  uart_hex_sample_loader #(
    .NUM_SAMPLES   (NS),
    .SAMPLE_BITLEN (SB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rvalid       (rvalid),
    .rready       (rready),
    .rdata        (rdata),
    .dac_req      (dac_req),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .state_out    (state_out),
    .load_count   (load_count),
    .err_count    (err_count)
`ifdef UART_HEX_SAMPLE_LOADER_ECHO_EN
    ,
    .tvalid       (tvalid),
    .tready       (tready),
    .tdata        (tdata)
`endif
  );

`ifndef UART_HEX_SAMPLE_LOADER_ECHO_EN
  assign tvalid = 1'b0;
  assign tdata  = 8'h00;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tb_req_d <= dac_req && exp_play;
    rst_d    <= rst;
  end

  // Output monitor: pulse timing, scoreboard order and hold between pulses.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_d) last_out = '0;
      checks++;
      if (sample_valid !== tb_req_d) begin
        errors++;
        $display("FAIL valid_timing: sample_valid=%b expected %b at %0t", sample_valid, tb_req_d, $time);
      end
      if (sample_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_sample: got %06h with empty scoreboard at %0t", sample_out, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          checks++;
          if (sample_out !== mon_exp) begin
            errors++;
            $display("FAIL sample_value: got %06h expected %06h at %0t", sample_out, mon_exp, $time);
          end
          last_out = mon_exp;
        end
      end else begin
        checks++;
        if (sample_out !== last_out) begin
          errors++;
          $display("FAIL sample_hold: got %06h expected %06h at %0t", sample_out, last_out, $time);
        end
      end
    end
  end

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit up);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else return (up ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rvalid = 1'b1;
    rdata  = b;
    n = 0;
    while (rready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL rready_timeout: byte %02h not accepted within 50 cycles", b);
      rvalid = 1'b0;
    end else begin
      @(posedge clk);
      #1 rvalid = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_line(input logic [SB-1:0] v, input int nd, input bit up);
    for (int i = nd - 1; i >= 0; i--) send_byte(hexc(v[i*4 +: 4], up));
    send_byte(8'h0D);
    send_byte(8'h0A);
  endtask

  task automatic strobe_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dac_req = 1'b1;
      exp_q.push_back(model[rd_model]);
      rd_model = (rd_model + 1) % NS;
    end
    @(negedge clk);
    dac_req = 1'b0;
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d samples outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rvalid = 1'b0; rdata = 8'h00; dac_req = 1'b0; tready = 1'b1;
    last_out = '0;
    tick(3);
    checks++;
    if ({rready, sample_valid, sample_out, state_out, load_count, err_count} !== {1'b0, 1'b0, 24'h0, 2'd0, 11'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_outputs: rready=%b sv=%b so=%06h st=%0d lc=%0d ec=%0d, expected all zero",
               rready, sample_valid, sample_out, state_out, load_count, err_count);
    end
    checks++;
    if ({tvalid, tdata} !== 9'h000) begin
      errors++;
      $display("FAIL reset_echo: tvalid=%b tdata=%02h expected 0/00", tvalid, tdata);
    end
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_load;
    send_byte(8'h4C);
    tick(3);
    checks++;
    if (state_out !== 2'd1 || load_count !== 11'd0) begin
      errors++;
      $display("FAIL enter_load: state=%0d lc=%0d expected 1/0", state_out, load_count);
    end
    for (int i = 0; i < NS; i++) begin
      model[i] = (i == 4) ? 24'hFFFFFF : 24'h00ABCD;
      send_line(model[i], 6, 1'b1);
    end
    tick(4);
    checks++;
    if (state_out !== 2'd2 || load_count !== 11'd1024 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL full_load: state=%0d lc=%0d ec=%0d expected 2/1024/0", state_out, load_count, err_count);
    end
    rd_model = 0;
    exp_play = 1'b1;
  endtask

  task automatic test_back_to_back;
    strobe_burst(NS + 6);
  endtask

  task automatic test_play_cmds;
    int n;
    // 'x' consumed in the same cycle as a dac_req: the request is still served.
    @(negedge clk);
    rvalid = 1'b1;
    rdata  = 8'h78;
    n = 0;
    while (rready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL cmd_x_timeout: byte not accepted within 50 cycles");
    end
    dac_req = 1'b1;
    exp_q.push_back(model[rd_model]);
    rd_model = (rd_model + 1) % NS;
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    dac_req = 1'b0;
    exp_play = 1'b0;
    tick(3);
    checks++;
    if (state_out !== 2'd0) begin
      errors++;
      $display("FAIL cmd_x: state=%0d expected 0", state_out);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) dac_req = 1'b1;
      @(negedge clk) dac_req = 1'b0;
    end
    send_byte(8'h6C);
    tick(3);
    checks++;
    if (state_out !== 2'd1 || load_count !== 11'd0) begin
      errors++;
      $display("FAIL cmd_l: state=%0d lc=%0d expected 1/0", state_out, load_count);
    end
  endtask

  task automatic test_line_errors;
    logic [SB-1:0] v;
    int nd;
    send_str("12G4\r\n");
    send_str("1234567\r\n");
    send_str("\r\n");
    send_line(24'h00007F, 2, 1'b1);
    model[0] = 24'h00007F;
    tick(3);
    checks++;
    if (err_count !== 8'd2 || load_count !== 11'd1 || state_out !== 2'd1) begin
      errors++;
      $display("FAIL line_errors: ec=%0d lc=%0d state=%0d expected 2/1/1", err_count, load_count, state_out);
    end
    for (int i = 1; i < NS; i++) begin
      v  = 24'(i * 32'h0001357B);
      nd = (i % 5 == 0) ? 4 : 6;
      if (nd == 4) v = v & 24'h00FFFF;
      model[i] = v;
      send_line(v, nd, (i % 2) == 1);
    end
    tick(4);
    checks++;
    if (state_out !== 2'd2 || load_count !== 11'd1024 || err_count !== 8'd2) begin
      errors++;
      $display("FAIL reload: state=%0d lc=%0d ec=%0d expected 2/1024/2", state_out, load_count, err_count);
    end
    rd_model = 0;
    exp_play = 1'b1;
    strobe_burst(12);
    exp_play = 1'b0;
  endtask

  task automatic test_reset_midload;
    send_byte(8'h4C);
    for (int i = 0; i < 10; i++) send_line(24'h123456 + 24'(i), 6, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rready, sample_valid, sample_out, state_out, load_count, err_count} !== {1'b0, 1'b0, 24'h0, 2'd0, 11'd0, 8'd0}) begin
      errors++;
      $display("FAIL midload_reset: rready=%b sv=%b so=%06h st=%0d lc=%0d ec=%0d, expected all zero",
               rready, sample_valid, sample_out, state_out, load_count, err_count);
    end
    rst = 1'b0;
    send_str("5\r\n");
    tick(3);
    checks++;
    if (state_out !== 2'd0 || load_count !== 11'd0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL idle_ignore: state=%0d lc=%0d ec=%0d expected 0/0/0", state_out, load_count, err_count);
    end
  endtask

`ifdef UART_HEX_SAMPLE_LOADER_ECHO_EN
  task automatic test_echo;
    int n;
    tready = 1'b0;
    send_byte(8'h41);
    tick(1);
    checks++;
    if (tvalid !== 1'b1 || tdata !== 8'h41) begin
      errors++;
      $display("FAIL echo_first: tvalid=%b tdata=%02h expected 1/41", tvalid, tdata);
    end
    @(negedge clk);
    rvalid = 1'b1;
    rdata  = 8'h42;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rready !== 1'b0) begin
        errors++;
        $display("FAIL echo_backpressure: rready=%b expected 0", rready);
      end
    end
    tready = 1'b1;
    @(negedge clk);
    tready = 1'b0;
    n = 0;
    while (rready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL echo_timeout: second byte not accepted");
    end
    @(posedge clk);
    #1 rvalid = 1'b0;
    tick(1);
    checks++;
    if (tvalid !== 1'b1 || tdata !== 8'h42) begin
      errors++;
      $display("FAIL echo_second: tvalid=%b tdata=%02h expected 1/42", tvalid, tdata);
    end
    tready = 1'b1;
    tick(2);
    checks++;
    if (tvalid !== 1'b0) begin
      errors++;
      $display("FAIL echo_drain: tvalid=%b expected 0", tvalid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_back_to_back();
    test_play_cmds();
    test_line_errors();
    test_reset_midload();
`ifdef UART_HEX_SAMPLE_LOADER_ECHO_EN
    test_echo();
`endif
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
